nibble_serial_addsub: RTL and testbench
=======================================

Name: nibble_serial_addsub

Overview:
- Multi-cycle wide adder/subtractor that sits in front of the 4-bit ripple add/sub datapath.
- Accepts WIDTH-bit operands and an add/sub select with a start/busy/done handshake.
- Processes one 4-bit nibble per clock, LSB nibble first, and carries between nibbles in a register.
- Presents registered result, carry-out and signed-overflow flags to the downstream consumer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4. Any other value is an elaboration error.
- NIB, WIDTH/4, number of nibble steps; derived, not overridable.

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when the block is not busy
- sub  input  1  0 = A+B, 1 = A-B (two's complement); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while nibble steps are in progress
- done  output  1  one-cycle pulse when res/cout/ovf become valid
- res  output  WIDTH  result; held until the next completion
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow (unsigned A >= B)
- ovf  output  1  signed overflow of the full-width operation

Behaviour:
- Reset: rst high at a clock edge forces state IDLE. busy, done, cout, ovf, res, nibble index and carry register all clear to 0. rst has priority over everything, including an in-flight operation; the aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Latch a into the A register.
  - Latch b XOR {WIDTH{sub}} into the B register.
  - Set the carry register to sub and the index to 0.
  - Go to RUN.
- IDLE or DONE with start=0: DONE goes to IDLE; IDLE stays in IDLE.
- RUN, each cycle:
  - nibble[idx] = A[idx] + B'[idx] + carry.
  - Write the sum into the shadow accumulator and the nibble carry-out into the carry register.
  - Increment idx.
- RUN at idx == NIB-1:
  - After that nibble, copy the accumulator to res and the final carry to cout.
  - Compute ovf = (A[MSB] == B'[MSB]) && (res[MSB] != A[MSB]).
  - Go to DONE.
- Timing:
  - start sampled high in cycle t: busy high in cycles t+1 .. t+NIB, done high only in cycle t+NIB+1.
  - Latency is NIB+1 cycles from start to done; 5 cycles at the default WIDTH.
- busy is high iff state == RUN. done is high iff state == DONE.
- start while busy is ignored (not queued), and the in-flight operation is unaffected.
- Back-to-back: start in the DONE cycle is accepted. busy rises the next cycle while res holds the previous result until the new completion.
- res, cout and ovf change only at completion, never mid-operation.
- Wrap-around: results are modulo 2^WIDTH; no saturation.
- Inter-nibble carry is never dropped: 0x000F+0x0001 must propagate into nibble 1.

Decomposition:
- Shared package holds:
  - localparam NIB_W = 4.
  - state enum {IDLE, RUN, DONE}.
  - function nib_count(width) with width-legality check.
- One sub-module is natural: nibble_adder with ports (A[3:0], B[3:0], Cin, Sum[3:0], Cout).
  - Pure 4-bit ripple of full adders with explicit carry-in.
  - B inversion happens in the controller at operand latch, so the carry chains correctly across nibbles.
- Controller contains the FSM, index counter, operand/accumulator registers and flag logic.

Test Plan:
- Add with nibble carry chain: a=0x1234, b=0x0FFF, sub=0 -> done at t+5, res=0x2233, cout=0, ovf=0; busy high exactly 4 cycles.
- Unsigned wrap: a=0xFFFF, b=0x0001, sub=0 -> res=0x0000, cout=1, ovf=0. Then a=0x000F, b=0x0001 -> res=0x0010.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> res=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005, sub=1 -> res=0x0002, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> res=0x8000, ovf=1. Then a=0x8000, b=0x0001, sub=1 -> res=0x7FFF, ovf=1, cout=1.
- Handshake:
  - start re-asserted with different operands during busy -> ignored; first result is delivered unchanged.
  - start in the DONE cycle -> accepted; second done exactly 5 cycles later.
  - done is never high for two consecutive cycles.
- Reset mid-operation: rst in cycle t+2 of an operation -> next cycle busy=0, done=0, res=0, cout=0, ovf=0. No done follows. A new start afterwards completes normally.

Source files
------------

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared constants, FSM state type and width helper for the nibble-serial add/sub.
package nibble_serial_addsub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns 0 for an illegal width so the caller can reject it at elaboration.
  function automatic int nib_count(input int width);
    if ((width < NIB_W) || ((width % NIB_W) != 0)) begin
      return 0;
    end
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_nibble_adder.sv
// 4-bit ripple-carry adder built from full adders with an explicit carry-in.
module nibble_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Wide add/sub processed one nibble per clock, LSB first, with a start/busy/done handshake.
// Result, carry-out and signed overflow are registered and only update at completion.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB   = WIDTH - 1;

  if (NIB == 0) begin : g_bad_width
    $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIB_W-1:0]   a_nib, b_nib, nib_sum;
  logic               nib_cout;

  assign a_nib = a_q[int'(idx_q) * NIB_W +: NIB_W];
  assign b_nib = b_q[int'(idx_q) * NIB_W +: NIB_W];

  nibble_adder u_nibble_adder (
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry_q),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // B is inverted here and carry seeded with sub so the chain does A + ~B + 1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[int'(idx_q) * NIB_W +: NIB_W] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NIB - 1)) begin
          res_d   = acc_d;
          cout_d  = nib_cout;
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (acc_d[MSB] != a_q[MSB]);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign res  = res_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench: directed vector table, handshake/reset sequences, random ops vs arithmetic model.
module tb_nibble_serial_addsub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] res;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] prev_res;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width values.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    longint ux, uy, sx, sy, ur, sr;
    logic   c, o;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);
    end else begin
      ur = ux + uy;
      sr = sx + sy;
      c  = (ur > 65535);
    end
    o = (sr > 32767) || (sr < -32768);
    return {o, c, ur[W-1:0]};
  endfunction

  // Call at a negedge sample point; returns at the done cycle's sample point.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] er, input logic ec, input logic eo,
                        input int inject_at);
    int lat, nbusy;
    bit got;
    start = 1'b1; a = x; b = y; sub = s;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nbusy = 0; got = 0;
    while (lat <= 20 && !got) begin
      if (done) begin
        got = 1;
      end else begin
        if (busy) begin
          nbusy++;
          check({tag, " res_held"}, 32'(res), 32'(prev_res));
        end
        if (lat == inject_at) begin
          start = 1'b1; a = ~x; b = x ^ 16'h5A5A; sub = ~s;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, got ? 32'(lat) : 32'd99, 32'd5);
    check({tag, " busy_cycles"}, 32'(nbusy), 32'd4);
    check({tag, " res"}, 32'(res), 32'(er));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    prev_res = er;
  endtask

  initial begin
    vec_t vecs[8];
    logic [W+1:0] m;
    logic [W-1:0] rx, ry;
    logic rs;
    int ndone;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset res", 32'(res), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    prev_res = '0;
    @(negedge clk);
    check("idle done", 32'(done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
             vecs[i].res, vecs[i].cout, vecs[i].ovf, 0);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
      check($sformatf("vec%0d idle_busy", i), 32'(busy), 32'd0);
    end

    // start during busy is ignored
    run_op("ign2", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 2);
    @(negedge clk);
    run_op("ign4", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
    // back-to-back: start in the DONE cycle
    run_op("b2b_a", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("b2b_b", 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("b2b done_pulse", 32'(done), 32'd0);

    // reset in cycle t+2 aborts the operation
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort res", 32'(res), 32'd0);
    check("abort cout", 32'(cout), 32'd0);
    check("abort ovf", 32'(ovf), 32'd0);
    prev_res = '0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort no_done", 32'(ndone), 32'd0);
    run_op("post_abort", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: rx = 16'h8000 | 16'($urandom_range(0, 3));
        1: rx = 16'h7FFF - 16'($urandom_range(0, 3));
        default: rx = 16'($urandom);
      endcase
      ry = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rs = 1'($urandom);
      m  = model(rx, ry, rs);
      run_op($sformatf("rnd%0d", i), rx, ry, rs, m[W-1:0], m[W], m[W+1],
             ($urandom_range(0, 3) == 0) ? 3 : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
